oserdes_pulse_generator: RTL and testbench
==========================================

# oserdes_pulse_generator

Generates a programmable train of rectangular pulses as 8-bit, MSB-first words for an OSERDES, one word per `clock`. It is the transmit-side counterpart of the ISERDES edge-counting scalers: each generated pulse produces exactly one 0→1 transition in the serial stream. Its main uses are channel stimulus and board-level loopback self-test of the scaler chain.

## Interface
Parameters:
- `BIT_DEPTH`, 8: bits per word; fixed at 8. `out[7]` is the earliest bit in time.
- `PERIOD_WIDTH`, 16: width of `period` and `width`, and of the internal phase counter.
- `COUNT_WIDTH`, 32: width of `pulse_count` and `pulses_sent`.

Ports:
- `clock`, input, 1: word clock (serial bit rate / 8).
- `reset_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: level-sampled; accepted only in IDLE.
- `stop`, input, 1: abort request.
- `period`, input, PERIOD_WIDTH: pulse period in bit-times; latched at accept.
- `width`, input, PERIOD_WIDTH: high time in bit-times; latched at accept.
- `pulse_count`, input, COUNT_WIDTH: number of pulses to send; 0 = continuous. Latched at accept.
- `out`, output, 8: serial word to the OSERDES.
- `busy`, output, 1: high in RUN.
- `done`, output, 1: one-cycle pulse at the end of a train.
- `error`, output, 1: sticky; set on a rejected start, cleared by the next accepted start.
- `pulses_sent`, output, COUNT_WIDTH: number of pulses begun since the last accepted start.

## Operation
- States: IDLE and RUN.
- IDLE → RUN: `start`=1 and `stop`=0, with legal parameters: `period` ≥ 2, `width` ≥ 1, `width` < `period`.
  - On accept: latch parameters, phase←0, `pulses_sent`←0, `error`←0.
- Rejected start (illegal parameters): `error`←1, stay IDLE, `out` stays 0.
- Word build, RUN only. Walk bits 7 down to 0 with running phase p:
  - If p==0 and (`pulse_count`==0 or `pulses_sent` + pulses begun this word < `pulse_count`), a pulse begins.
  - bit = 1 iff p < `width` and the current pulse is active.
  - Next p = (p+1 == `period`) ? 0 : p+1.
  - Multiple pulses per word are legal when `period` < 8.
- Phase carries across words without a gap. `pulses_sent` increases by the number of pulses begun in the word (0 to 4).
- Finite train: after the last pulse's `period` bit-times elapse, remaining bits are 0, then RUN → IDLE and `done`=1.
  - The transition happens on the same edge that registers the word where the last period completes.
- `stop`=1 in RUN: the next registered word is 0x00, RUN → IDLE, `done`=1. The pulse in progress is truncated.
- `stop` and `start` together in IDLE: stop wins, start is ignored, no `error`.
- `start` while busy is ignored.
- Arithmetic: phase compare is unsigned. `pulses_sent` saturates at all-ones in continuous mode and does not wrap.

## Timing
- Reset values: `out`=0, `busy`=0, `done`=0, `error`=0, `pulses_sent`=0, state IDLE. Reset applies asynchronously, including mid-train.
- `start` sampled at edge k → `busy`=1 after k. The first pulse word is registered at edge k+1, so bit 7 is high after k+1.
- `out` is fully registered; there is no combinational path from the inputs to `out`.
- `done` is high for exactly one cycle, coincident with `busy` falling. The first idle word (0x00) follows the same edge.
- A new `start` is accepted on the cycle `done` is high (state is already IDLE).

## Structure
- Shared package (`pulse_generator_pkg`):
  - state localparams `PG_IDLE`/`PG_RUN`
  - `PG_MIN_PERIOD`=2
- Sub-module `oserdes_word_builder`: purely combinational 8-bit walk.
  - Inputs: phase, period, width, pulses remaining, continuous flag.
  - Outputs: word, next phase, pulses begun (3 bits).
- The top level holds the FSM, latches, counters and output register.

## Test plan
- `period`=8, `width`=4, `pulse_count`=3 → `out` 0xF0, 0xF0, 0xF0, then 0x00; `done` coincides with the third 0xF0; `pulses_sent`=3.
- `period`=20, `width`=10, `pulse_count`=2 → words 0xFF, 0xC0, 0x0F, 0xFC, 0x00, 0x00. IDLE follows the word whose period ends; `pulses_sent`=2.
- `period`=3, `width`=1, continuous → repeating 0x92, 0x49, 0x24. Assert `stop` → next word 0x00, `done`=1.
- `width`=5, `period`=5 (illegal) with `start` → `error`=1, `busy`=0, `out`=0. A legal start then clears `error`.
- Loopback into `iserdes_counter` with `period`=5, `width`=2, `pulse_count`=1000 → counter reads 1000.
- Deassert `reset_n` mid-train → `out`, `busy` and `pulses_sent` go to 0 immediately. After release, no output until a new `start`.

Source files
------------

// File: rtl/pulse_generator_pkg.sv
// Shared types and constants for the OSERDES pulse generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pulse_generator_pkg;

    typedef enum logic {
        PG_IDLE = 1'b0,
        PG_RUN  = 1'b1
    } pg_state_t;

    localparam int PG_MIN_PERIOD = 2;
    localparam int PG_WORD_BITS  = 8;

endpackage

// File: rtl/oserdes_word_builder.sv
// Walks one 8-bit MSB-first word of the pulse train from the current phase.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the word is consumed.
module oserdes_word_builder
    import pulse_generator_pkg::*;
#(
    parameter int PERIOD_WIDTH = 16,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic [PERIOD_WIDTH-1:0] phase,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic [PERIOD_WIDTH-1:0] width,
    input  logic [COUNT_WIDTH-1:0]  remaining,
    input  logic                    continuous,
    output logic [PG_WORD_BITS-1:0] word,
    output logic [PERIOD_WIDTH-1:0] next_phase,
    output logic [2:0]              begun,
    output logic                    train_done
);

    logic [PERIOD_WIDTH-1:0] p;
    logic                    active;
    logic [2:0]              n;

    // A pulse is always in progress on entry: RUN is left on the word where
    // the last period wraps, so a mid-period phase implies an active pulse.
    always_comb begin
        p          = phase;
        active     = 1'b1;
        n          = 3'd0;
        word       = '0;
        train_done = 1'b0;
        for (int i = PG_WORD_BITS - 1; i >= 0; i--) begin
            if (p == '0) begin
                active = continuous || ({{(COUNT_WIDTH-3){1'b0}}, n} < remaining);
                if (active) begin
                    n = n + 3'd1;
                end
            end
            word[i] = active && (p < width);
            if (p + 1'b1 == period) begin
                p = '0;
                if (!continuous && ({{(COUNT_WIDTH-3){1'b0}}, n} == remaining)) begin
                    train_done = 1'b1;
                end
            end else begin
                p = p + 1'b1;
            end
        end
        next_phase = p;
        begun      = n;
    end

endmodule

// File: rtl/oserdes_pulse_generator.sv
// Programmable rectangular pulse train emitted as 8-bit MSB-first OSERDES words.
// Latency: start at edge k -> busy after k, first pulse word registered at k+1.
// Backpressure: none; one word per clock, stop aborts with a zero word.
module oserdes_pulse_generator
    import pulse_generator_pkg::*;
#(
    parameter int BIT_DEPTH    = 8,
    parameter int PERIOD_WIDTH = 16,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic [PERIOD_WIDTH-1:0] width,
    input  logic [COUNT_WIDTH-1:0]  pulse_count,
    output logic [BIT_DEPTH-1:0]    out,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [COUNT_WIDTH-1:0]  pulses_sent
);

    pg_state_t               state, state_next;
    logic [PERIOD_WIDTH-1:0] period_q, width_q, phase;
    logic [COUNT_WIDTH-1:0]  count_q;
    logic [PG_WORD_BITS-1:0] word;
    logic [PERIOD_WIDTH-1:0] next_phase;
    logic [2:0]              begun;
    logic                    train_done;
    logic                    params_legal;
    logic                    accept, reject, finish, advance;
    logic [COUNT_WIDTH:0]    sent_sum;

    assign params_legal = (period >= PERIOD_WIDTH'(PG_MIN_PERIOD)) &&
                          (width != '0) && (width < period);
    assign advance  = (state == PG_RUN) && !stop;
    assign sent_sum = {1'b0, pulses_sent} + (COUNT_WIDTH+1)'(begun);
    assign busy     = (state == PG_RUN);

    oserdes_word_builder #(
        .PERIOD_WIDTH (PERIOD_WIDTH),
        .COUNT_WIDTH  (COUNT_WIDTH)
    ) u_word_builder (
        .phase      (phase),
        .period     (period_q),
        .width      (width_q),
        .remaining  (count_q - pulses_sent),
        .continuous (count_q == '0),
        .word       (word),
        .next_phase (next_phase),
        .begun      (begun),
        .train_done (train_done)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= PG_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Stop outranks both a start in IDLE and natural completion in RUN.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        finish     = 1'b0;
        case (state)
            PG_IDLE: begin
                if (start && !stop) begin
                    if (params_legal) begin
                        accept     = 1'b1;
                        state_next = PG_RUN;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            PG_RUN: begin
                if (stop || train_done) begin
                    finish     = 1'b1;
                    state_next = PG_IDLE;
                end
            end
            default: state_next = PG_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            period_q    <= '0;
            width_q     <= '0;
            count_q     <= '0;
            phase       <= '0;
            pulses_sent <= '0;
            out         <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            out  <= advance ? word : '0;
            done <= finish;
            if (accept) begin
                period_q    <= period;
                width_q     <= width;
                count_q     <= pulse_count;
                phase       <= '0;
                pulses_sent <= '0;
                error       <= 1'b0;
            end else if (reject) begin
                error <= 1'b1;
            end
            if (advance) begin
                phase       <= next_phase;
                pulses_sent <= sent_sum[COUNT_WIDTH] ? '1 : sent_sum[COUNT_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_oserdes_pulse_generator.sv
// Bench for oserdes_pulse_generator: directed and random trains against a bit-timeline model.
// Latency: n/a.
// Backpressure: n/a.
module tb_oserdes_pulse_generator;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start, stop;
    logic [15:0] period, width;
    logic [31:0] pulse_count;
    logic [7:0]  out;
    logic        busy, done, error;
    logic [31:0] pulses_sent;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    oserdes_pulse_generator dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .period      (period),
        .width       (width),
        .pulse_count (pulse_count),
        .out         (out),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .pulses_sent (pulses_sent)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Serial timeline: pulse j occupies bits [j*P, j*P+W); a finite train lasts N*P bits.
    function automatic logic [7:0] model_word(input int p, input int w, input int n, input int k);
        logic [7:0] r;
        int t;
        r = 8'h00;
        for (int b = 0; b < 8; b++) begin
            t = 8 * k + b;
            r[7-b] = ((n == 0) || (t < n * p)) && ((t % p) < w);
        end
        return r;
    endfunction

    function automatic int model_sent(input int p, input int n, input int k);
        int s;
        s = (8 * k + 7) / p + 1;
        if (n != 0 && s > n) s = n;
        return s;
    endfunction

    task automatic idle_check(input string tag);
        step();
        check({tag, "_out"},  64'(out),  64'h0);
        check({tag, "_busy"}, 64'(busy), 64'h0);
        check({tag, "_done"}, 64'(done), 64'h0);
    endtask

    // Ends right after the last word (done high) so the caller may chain a start.
    task automatic run_train(input int p, input int w, input int n, input int cont_words, input bit noise);
        int  nw;
        bit  last;
        period      = 16'(p);
        width       = 16'(w);
        pulse_count = 32'(n);
        start = 1'b1;
        stop  = 1'b0;
        step();
        start = 1'b0;
        check("accept_busy", 64'(busy),        64'h1);
        check("accept_out",  64'(out),         64'h0);
        check("accept_sent", 64'(pulses_sent), 64'h0);
        check("accept_err",  64'(error),       64'h0);
        check("accept_done", 64'(done),        64'h0);
        nw = (n != 0) ? (n * p + 7) / 8 : cont_words;
        for (int k = 0; k < nw; k++) begin
            step();
            last = (n != 0) && (k == nw - 1);
            check("word",      64'(out),         64'(model_word(p, w, n, k)));
            check("word_sent", 64'(pulses_sent), 64'(model_sent(p, n, k)));
            check("word_busy", 64'(busy),        64'(!last));
            check("word_done", 64'(done),        64'(last));
            if (noise && !last) begin
                start       = 1'($urandom_range(0, 1));
                period      = 16'($urandom);
                width       = 16'($urandom);
                pulse_count = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        if (n == 0) begin
            start = 1'b0;
            stop  = 1'b1;
            step();
            stop = 1'b0;
            check("stop_out",  64'(out),         64'h0);
            check("stop_done", 64'(done),        64'h1);
            check("stop_busy", 64'(busy),        64'h0);
            check("stop_sent", 64'(pulses_sent), 64'(model_sent(p, 0, nw - 1)));
        end
    endtask

    task automatic try_illegal(input int p, input int w, input string tag);
        period      = 16'(p);
        width       = 16'(w);
        pulse_count = 32'd3;
        start = 1'b1;
        stop  = 1'b0;
        step();
        start = 1'b0;
        check({tag, "_err"},  64'(error), 64'h1);
        check({tag, "_busy"}, 64'(busy),  64'h0);
        check({tag, "_out"},  64'(out),   64'h0);
    endtask

    initial begin
        int p, w, n;
        reset_n     = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        period      = '0;
        width       = '0;
        pulse_count = '0;
        #2;
        check("rst_out",  64'(out),         64'h0);
        check("rst_busy", 64'(busy),        64'h0);
        check("rst_done", 64'(done),        64'h0);
        check("rst_err",  64'(error),       64'h0);
        check("rst_sent", 64'(pulses_sent), 64'h0);
        step();
        reset_n = 1'b1;
        idle_check("idle0");

        // Directed trains: one pulse per word, pulses spanning words, several per word.
        run_train(8, 4, 3, 0, 1'b0);
        check("t1_last", 64'(out), 64'hF0);
        idle_check("t1_idle");
        run_train(20, 10, 2, 0, 1'b0);
        idle_check("t2_idle");
        run_train(3, 1, 0, 6, 1'b0);
        check("t3_sent", 64'(pulses_sent), 64'd16);
        idle_check("t3_idle");

        // Rejected start, then a legal start on the done cycle clears the error.
        try_illegal(5, 5, "ill_eq");
        run_train(5, 2, 4, 0, 1'b0);
        run_train(6, 2, 1, 0, 1'b0);
        idle_check("chain_idle");

        // Start and stop together: stop wins, no error even with bad parameters.
        period = 16'd4;
        width  = 16'd9;
        start  = 1'b1;
        stop   = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_busy", 64'(busy),  64'h0);
        check("ss_err",  64'(error), 64'h0);
        try_illegal(1, 0, "ill_p1");
        try_illegal(10, 0, "ill_w0");
        try_illegal(4, 7, "ill_wgt");

        // Random trains with ignored start/parameter noise while busy.
        for (int r = 0; r < 12; r++) begin
            p = $urandom_range(2, 24);
            w = $urandom_range(1, p - 1);
            n = (r % 4 == 3) ? 0 : $urandom_range(1, 6);
            run_train(p, w, n, $urandom_range(1, 8), 1'b1);
            if (r % 2 == 1) idle_check("rnd_idle");
        end
        idle_check("rnd_end");

        // Asynchronous reset in the middle of a continuous train.
        period      = 16'd7;
        width       = 16'd3;
        pulse_count = 32'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("mid_word", 64'(out), 64'(model_word(7, 3, 0, 1)));
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_out",  64'(out),         64'h0);
        check("arst_busy", 64'(busy),        64'h0);
        check("arst_sent", 64'(pulses_sent), 64'h0);
        step();
        reset_n = 1'b1;
        idle_check("post_rst0");
        idle_check("post_rst1");
        idle_check("post_rst2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
